// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch front end with a small prefetch FIFO.
//
// Owns the fetch PC and drives the ROM byte address. Each cycle the queue has
// room, it captures the returned word with its PC. The head entry goes to
// decode over a valid/ready handshake. A redirect from execute flushes the
// queue and re-steers the fetch PC.
//
// Optional feature macro: FETCH_ALIGN_CHECK_EN
//   When defined, a redirect to a target that is not word aligned still
//   flushes the queue and loads the PC. It also halts fetch and sets the
//   sticky misalign flag. The next aligned redirect releases the halt.
//   When undefined, the target's low two bits are forced to zero.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   imem_addr  (out)           ROM byte address, copy of fetch PC
//   imem_rd    (in)            ROM data for imem_addr, same cycle
//   redirect_valid/_pc (in)    re-steer request and target
//   instr_valid/instr/instr_pc head entry (instr/instr_pc are zero when empty)
//   instr_ready (in)           decode accepts head
//   count      (out)           queue occupancy
//   misalign   (out)           sticky misaligned-redirect flag (macro only)
module fetch_queue #(
    parameter int unsigned         A_WIDTH  = 32,
    parameter int unsigned         I_WIDTH  = 32,
    parameter int unsigned         DEPTH    = 4,
    parameter logic [A_WIDTH-1:0]  RESET_PC = A_WIDTH'(32'hBFC00000)
) (
    input  logic                          clk,
    input  logic                          rst,
    output logic [A_WIDTH-1:0]            imem_addr,
    input  logic [I_WIDTH-1:0]            imem_rd,
    input  logic                          redirect_valid,
    input  logic [A_WIDTH-1:0]            redirect_pc,
    output logic                          instr_valid,
    output logic [I_WIDTH-1:0]            instr,
    output logic [A_WIDTH-1:0]            instr_pc,
    input  logic                          instr_ready,
    output logic [$clog2(DEPTH+1)-1:0]    count
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    output logic                          misalign
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [A_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [A_WIDTH-1:0] pc_q   [DEPTH];
    logic [A_WIDTH-1:0] pc_d   [DEPTH];
    logic [I_WIDTH-1:0] word_q [DEPTH];
    logic [I_WIDTH-1:0] word_d [DEPTH];

    logic deq;
    logic push;
    logic halt;
    logic [A_WIDTH-1:0] redirect_tgt;

`ifdef FETCH_ALIGN_CHECK_EN
    logic halt_q, halt_d;
    logic misalign_q, misalign_d;
    logic redirect_misaligned;

    assign halt                = halt_q;
    assign misalign            = misalign_q;
    assign redirect_misaligned = (redirect_pc[1:0] != 2'b00);
    assign redirect_tgt        = redirect_pc;
`else
    logic unused_redirect_lsb;

    assign halt                = 1'b0;
    assign redirect_tgt        = {redirect_pc[A_WIDTH-1:2], 2'b00};
    assign unused_redirect_lsb = ^redirect_pc[1:0];
`endif

    // Handshake and push qualification; a full queue may push while it dequeues.
    assign deq  = (count_q != '0) & instr_ready;
    assign push = !redirect_valid & !halt & ((count_q < CNT_W'(DEPTH)) | deq);

    // Next-state: redirect flushes and re-steers, otherwise push/deq bookkeeping.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        pc_d       = pc_q;
        word_d     = word_q;
`ifdef FETCH_ALIGN_CHECK_EN
        halt_d     = halt_q;
        misalign_d = misalign_q;
`endif

        if (redirect_valid) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            fetch_pc_d = redirect_tgt;
`ifdef FETCH_ALIGN_CHECK_EN
            halt_d = redirect_misaligned;
            if (redirect_misaligned) begin
                misalign_d = 1'b1;
            end
`endif
        end else begin
            if (push) begin
                pc_d[wr_ptr_q]   = fetch_pc_q;
                word_d[wr_ptr_q] = imem_rd;
                wr_ptr_d         = wr_ptr_q + PTR_W'(1);
                fetch_pc_d       = fetch_pc_q + A_WIDTH'(4);
            end
            if (deq) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push && !deq) begin
                count_d = count_q + CNT_W'(1);
            end else if (deq && !push) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                pc_q[i]   <= '0;
                word_q[i] <= '0;
            end
`ifdef FETCH_ALIGN_CHECK_EN
            halt_q     <= 1'b0;
            misalign_q <= 1'b0;
`endif
        end else begin
            fetch_pc_q <= fetch_pc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            pc_q       <= pc_d;
            word_q     <= word_d;
`ifdef FETCH_ALIGN_CHECK_EN
            halt_q     <= halt_d;
            misalign_q <= misalign_d;
`endif
        end
    end

    // Outputs are pure functions of registered state.
    assign imem_addr   = fetch_pc_q;
    assign count       = count_q;
    assign instr_valid = (count_q != '0);
    assign instr       = instr_valid ? word_q[rd_ptr_q] : '0;
    assign instr_pc    = instr_valid ? pc_q[rd_ptr_q]   : '0;

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed stimulus for fetch_queue with a queue-based
// reference model compared on every cycle, plus literal spot checks.
module tb_fetch_queue;

    logic        clk;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_rd;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic [2:0]  count;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        misalign;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 0;

    fetch_queue dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_rd        (imem_rd),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready),
        .count          (count)
`ifdef FETCH_ALIGN_CHECK_EN
        ,
        .misalign       (misalign)
`endif
    );

    // ROM contents: upper half = address low half, lower half = its complement.
    function automatic logic [31:0] rom(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    assign imem_rd = rom(imem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: queue of {pc, word}, fetch pc, halt, sticky flag.
    logic [63:0] mq[$];
    logic [31:0] m_pc;
    bit          m_halt;
    bit          m_mis;

    always @(posedge clk) begin
        bit m_deq, m_push;
        if (rst) begin
            mq.delete();
            m_pc   = 32'hBFC00000;
            m_halt = 0;
            m_mis  = 0;
        end else begin
            m_deq  = (mq.size() != 0) && instr_ready;
            m_push = !redirect_valid && !m_halt && ((mq.size() < 4) || m_deq);
            if (redirect_valid) begin
                mq.delete();
`ifdef FETCH_ALIGN_CHECK_EN
                m_pc   = redirect_pc;
                m_halt = (redirect_pc % 4) != 0;
                if (m_halt) m_mis = 1;
`else
                m_pc = redirect_pc - (redirect_pc % 4);
`endif
            end else begin
                if (m_deq) void'(mq.pop_front());
                if (m_push) begin
                    mq.push_back({m_pc, rom(m_pc)});
                    m_pc = m_pc + 32'd4;
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            logic [63:0] head;
            head = (mq.size() != 0) ? mq[0] : 64'd0;
            chk("m_instr_valid", {31'd0, instr_valid}, {31'd0, mq.size() != 0});
            chk("m_instr",       instr,      head[31:0]);
            chk("m_instr_pc",    instr_pc,   head[63:32]);
            chk("m_count",       {29'd0, count}, 32'(mq.size()));
            chk("m_imem_addr",   imem_addr,  m_pc);
`ifdef FETCH_ALIGN_CHECK_EN
            chk("m_misalign",    {31'd0, misalign}, {31'd0, m_mis});
`endif
        end
    end

    // Apply inputs, then wait until the following falling edge.
    task automatic drive(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy);
        rst            = r;
        redirect_valid = rv;
        redirect_pc    = rpc;
        instr_ready    = rdy;
        @(negedge clk);
    endtask

    initial begin
        logic [23:0] rdy_pat;
        rdy_pat = 24'b1011_0010_1110_0111_0001_1011;
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b0;

        // Reset values
        drive(1, 0, 0, 0);
        chk_en = 1;
        drive(1, 0, 0, 1);
        chk("rst_count", {29'd0, count}, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_addr",  imem_addr, 32'hBFC00000);
        chk("rst_instr", instr, 32'd0);
        chk("rst_pc",    instr_pc, 32'd0);

        // Streaming with ready high: one per cycle, count stays 1
        drive(0, 0, 0, 1);
        chk("s0_pc",    instr_pc, 32'hBFC00000);
        chk("s0_instr", instr,    32'h0000FFFF);
        chk("s0_count", {29'd0, count}, 32'd1);
        drive(0, 0, 0, 1);
        chk("s1_pc",    instr_pc, 32'hBFC00004);
        chk("s1_instr", instr,    32'h0004FFFB);
        chk("s1_count", {29'd0, count}, 32'd1);
        drive(0, 0, 0, 1);
        drive(0, 0, 0, 1);
        chk("s3_pc",    instr_pc, 32'hBFC0000C);

        // Fill with ready low
        drive(1, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            drive(0, 0, 0, 0);
            chk("fill_count", {29'd0, count}, (i < 4) ? 32'(i + 1) : 32'd4);
        end
        chk("fill_addr", imem_addr, 32'hBFC00010);
        chk("fill_head", instr_pc,  32'hBFC00000);

        // Full queue push + deq in the same cycle
        drive(0, 0, 0, 1);
        chk("full_count", {29'd0, count}, 32'd4);
        chk("full_pc",    instr_pc, 32'hBFC00004);
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 1);
        chk("full_pc4",   instr_pc, 32'hBFC00014);

        // Redirect with count = 3 and ready high
        drive(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 0);
        chk("pre_rd_count", {29'd0, count}, 32'd3);
        drive(0, 1, 32'hBFC00100, 1);
        chk("rd_valid", {31'd0, instr_valid}, 32'd0);
        chk("rd_addr",  imem_addr, 32'hBFC00100);
        drive(0, 0, 0, 1);
        chk("rd_pc",    instr_pc, 32'hBFC00100);
        chk("rd_instr", instr,    32'h0100FEFF);

        // Misaligned redirect
        drive(0, 1, 32'hBFC00102, 1);
`ifdef FETCH_ALIGN_CHECK_EN
        chk("mis_flag", {31'd0, misalign}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 1);
            chk("mis_halt_count", {29'd0, count}, 32'd0);
        end
        drive(0, 1, 32'hBFC00200, 1);
        drive(0, 0, 0, 1);
        chk("mis_resume_pc", instr_pc, 32'hBFC00200);
        chk("mis_sticky", {31'd0, misalign}, 32'd1);
`else
        chk("mis_addr", imem_addr, 32'hBFC00100);
        drive(0, 0, 0, 1);
        chk("mis_pc", instr_pc, 32'hBFC00100);
`endif

        // Mixed ready pattern with a mid-stream redirect
        for (int i = 0; i < 24; i++) begin
            if (i == 10) drive(0, 1, 32'hBFC00300, rdy_pat[i]);
            else         drive(0, 0, 0, rdy_pat[i]);
        end

        // Reset mid-stream with count = 2 overrides a redirect
        drive(1, 0, 0, 0);
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        chk("mrst_pre_count", {29'd0, count}, 32'd2);
        drive(1, 1, 32'hBFC00400, 1);
        chk("mrst_count", {29'd0, count}, 32'd0);
        chk("mrst_addr",  imem_addr, 32'hBFC00000);
        drive(0, 0, 0, 1);
        chk("mrst_pc",    instr_pc, 32'hBFC00000);
        chk("mrst_instr", instr,    32'h0000FFFF);
        drive(0, 0, 0, 1);
        chk("mrst_pc1",   instr_pc, 32'hBFC00004);

        chk_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
